ysyx_22050612_lsu: RTL
======================

# ysyx_22050612_lsu

Multi-cycle, parametrised load/store unit that sits between the execute stage and the data-memory port, replacing the combinational single-access memory path. It accepts one access per request handshake, aligns store data and byte mask to the memory lane, and waits on a valid/ready memory interface. It returns sign- or zero-extended load data with its destination register. Misaligned accesses are detected and reported without touching memory.

## Interface
- `XLEN`, 64: data width; only 32 or 64 are legal.
- `AW`, 64: address width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: access request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 double.
- `req_unsigned` in 1: zero-extend the load result (ignored for stores).
- `req_addr` in AW: byte address.
- `req_wdata` in XLEN: store data, right-justified.
- `req_rd` in 5: load destination register, echoed on the response.
- `mem_valid` out 1: memory request.
- `mem_ready` in 1: memory accepts the request.
- `mem_wen` out 1: memory write.
- `mem_addr` out AW: lane-aligned address, low log2(XLEN/8) bits forced to 0.
- `mem_wdata` out XLEN: lane-shifted store data.
- `mem_wmask` out XLEN/8: byte enables.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in XLEN: read data for the whole lane.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes the result.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_rd` out 5: echoed `req_rd`; 0 for stores.
- `resp_err` out 1: misaligned or illegal size.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch all request fields. Go to RESP with `resp_err`=1 if the access is bad, otherwise go to MEM.
  - MEM: `mem_valid`=1 and held with stable outputs until `mem_ready`. Then a store goes to RESP and a load goes to WAIT.
  - WAIT: capture `mem_rdata` on `mem_rvalid`, then go to RESP. `mem_rvalid` arriving in any other state is ignored.
  - RESP: `resp_valid`=1 and held with stable outputs until `resp_ready`, then go to IDLE. There is no bypass to a new request in the same cycle.
- An access is bad if `addr` mod (1<<size) ≠ 0, or if size = 3 while XLEN = 32.
- Lane offset is `off` = `addr[log2(XLEN/8)-1:0]`.
  - `mem_wdata` = `req_wdata` << (8·off).
  - `mem_wmask` = ((1<<(1<<size))−1) << off.
  - For loads: `mem_wen`=0 and `mem_wmask`=0.
- Load result: `mem_rdata` >> (8·off), truncated to 8·(1<<size) bits. The result is sign-extended unless `req_unsigned`, and is XLEN-wide. At full width (size = log2(XLEN/8)) the data passes through unchanged.
- Reset values: state IDLE; `req_ready`=1; `busy`=0; all valid outputs 0; all data, address, mask and rd outputs 0.
- Reset mid-operation abandons the access: `mem_valid` and `resp_valid` are 0 in the cycle after reset is sampled. A late `mem_rvalid` is discarded.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from `mem_*` inputs to `mem_*` outputs.
- The request handshake completes at edge E0.
  - MEM is entered at E0; `mem_valid` is visible in cycle 1.
  - With `mem_ready`=1 in cycle 1, a store shows `resp_valid` in cycle 2 (2-cycle latency).
  - For a load with `mem_rvalid` in cycle 2, `resp_valid` is in cycle 3 (3-cycle latency).
  - For a bad access, `resp_valid` is in cycle 1.
- Every added stall cycle (`mem_ready`=0, `mem_rvalid`=0, `resp_ready`=0) adds exactly one cycle.
- Maximum throughput is one access per 3 cycles for stores and 4 cycles for loads.

## Structure
- Package `ysyx_22050612_lsu_pkg` holds:
  - the size encoding constants (SZ_B/H/W/D);
  - the FSM state enum (IDLE, MEM, WAIT, RESP).
- Sub-module `ysyx_22050612_lsu_align` is purely combinational. It is parametrised by XLEN and generates:
  - the store shift and mask;
  - the load shift and extension;
  - the misalignment check.
- The FSM, registers and handshakes live in the top module.

## Test plan
- XLEN=64, store byte 0xAB to addr 0x8000_0003, `mem_ready` in cycle 1 -> `mem_addr`=0x8000_0000, `mem_wmask`=0x08, `mem_wdata[31:24]`=0xAB, `resp_valid` in cycle 2, `resp_err`=0.
- Signed load half from 0x…06, `mem_rdata`=0x8001_xxxx_xxxx_xxxx -> `resp_rdata`=0xFFFF_FFFF_FFFF_8001. Repeat with `req_unsigned`=1 -> 0x0000_0000_0000_8001. In both cases `resp_rd` equals `req_rd`.
- Load word from 0x…02 -> `resp_err`=1 in cycle 1, `mem_valid` never asserted, `resp_rdata`=0.
- `mem_ready` held low 5 cycles, then `resp_ready` low 3 cycles -> `mem_*` and `resp_*` stable throughout, `req_ready`=0 until the cycle after the response handshake.
- Assert reset while in WAIT, then pulse `mem_rvalid` after reset -> all outputs at reset values, no `resp_valid`, next request completes normally.
- XLEN=32, size=3 load -> `resp_err`=1. Word load at 0x…4 -> `mem_wmask`=0, `resp_rdata` equals `mem_rdata`.

Source files
------------

// File: rtl/ysyx_22050612_lsu_pkg.sv
// ysyx_22050612_lsu_pkg: access-size encodings and LSU FSM states.
package ysyx_22050612_lsu_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    typedef enum logic [1:0] {IDLE, MEM, WAIT, RESP} state_e;
endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// ysyx_22050612_lsu_align: lane alignment of store data/mask, load extraction/extension, misalignment check.
module ysyx_22050612_lsu_align
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int OW = $clog2(XLEN / 8),
    localparam int MW = XLEN / 8
) (
    input  logic [1:0]      size_i,
    input  logic [OW-1:0]   off_i,
    input  logic            uns_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [MW-1:0]   wmask_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            bad_o
);
    logic [7:0] base;
    logic [6:0] amt;
    logic [XLEN-1:0] rsh, rshl;
    logic signed [XLEN-1:0] sext;
    // Extension: park the field at the top, then shift back logically or arithmetically.
    always_comb begin
        base = size_i == SZ_B ? 8'h01 : size_i == SZ_H ? 8'h03 : size_i == SZ_W ? 8'h0F : 8'hFF;
        amt = ({1'b0, size_i} >= 3'(OW)) ? 7'd0 : 7'(XLEN - (8 << size_i));
        rsh = rdata_i >> {off_i, 3'b000};
        rshl = rsh << amt;
        sext = $signed(rshl) >>> amt;
    end
    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign wmask_o = MW'(base) << off_i;
    assign rdata_o = uns_i ? rshl >> amt : sext;
    assign bad_o = (|(off_i & OW'((1 << size_i) - 1))) | (size_i == SZ_D && XLEN == 32);
endmodule

// File: rtl/ysyx_22050612_lsu.sv
// ysyx_22050612_lsu: multi-cycle load/store unit between execute and a valid/ready data-memory port.
module ysyx_22050612_lsu
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              busy_o
);
    localparam int OW = $clog2(XLEN / 8);
    localparam int MW = XLEN / 8;
    state_e state_q, state_d;
    logic [AW-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q, rdata_q, a_wdata, a_rdata;
    logic [MW-1:0] mem_wmask_q, a_wmask;
    logic mem_wen_q, uns_q, err_q, a_bad, idle;
    logic [1:0] size_q, a_size;
    logic [OW-1:0] off_q, a_off;
    logic [4:0] rd_q;
    // The aligner sees the live request while idle and the latched access afterwards.
    assign idle = state_q == IDLE;
    assign a_size = idle ? req_size_i : size_q;
    assign a_off = idle ? req_addr_i[OW-1:0] : off_q;
    ysyx_22050612_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i (a_size),
        .off_i  (a_off),
        .uns_i  (uns_q),
        .wdata_i(req_wdata_i),
        .rdata_i(mem_rdata_i),
        .wdata_o(a_wdata),
        .wmask_o(a_wmask),
        .rdata_o(a_rdata),
        .bad_o  (a_bad)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = a_bad ? RESP : MEM;
            MEM:     if (mem_ready_i) state_d = mem_wen_q ? RESP : WAIT;
            WAIT:    if (mem_rvalid_i) state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_wen_q   <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            uns_q       <= 1'b0;
            rd_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idle && req_valid_i) begin
                mem_addr_q  <= {req_addr_i[AW-1:OW], OW'(0)};
                mem_wdata_q <= req_wen_i ? a_wdata : '0;
                mem_wmask_q <= req_wen_i ? a_wmask : '0;
                mem_wen_q   <= req_wen_i;
                size_q      <= req_size_i;
                off_q       <= req_addr_i[OW-1:0];
                uns_q       <= req_unsigned_i;
                rd_q        <= req_wen_i ? 5'd0 : req_rd_i;
                rdata_q     <= '0;
                err_q       <= a_bad;
            end
            if (state_q == WAIT && mem_rvalid_i) rdata_q <= a_rdata;
        end
    end
    assign req_ready_o  = idle;
    assign busy_o       = !idle;
    assign mem_valid_o  = state_q == MEM;
    assign mem_wen_o    = mem_wen_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wmask_o  = mem_wmask_q;
    assign resp_valid_o = state_q == RESP;
    assign resp_rdata_o = rdata_q;
    assign resp_rd_o    = rd_q;
    assign resp_err_o   = err_q;
endmodule
